// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encoding,
// default address parameters and next-PC mux select codes.
package pc_sequencer_pkg;

  localparam int          ADDR_W_DEF   = 11;
  localparam logic [10:0] RESET_PC_DEF = 11'd0;
  localparam int          CNT_W_DEF    = 16;

  localparam logic MUX_SEL_INC = 1'b0;
  localparam logic MUX_SEL_JMP = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter used for the debug fetch count; sticks at all-ones.
module pc_sequencer_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, drives the external next-PC mux select,
// registers the mux result, flags wrong-path fetches and supports halt/resume.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  input  logic              resume,
  input  logic [ADDR_W-1:0] mux_value,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              mux_sel,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  // Handshake: redirect_valid has no ready; it is accepted in every cycle it
  // is high (RUN or HALT), the mux is switched to the target that same cycle
  // and pc takes the target on the next edge. redirect_target only matters
  // through the external mux, so it is not read here.
  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              count_en;

  assign pc_plus1 = pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    mux_sel    = MUX_SEL_INC;
    flush      = 1'b0;
    pc_valid   = 1'b0;
    halted     = 1'b0;
    count_en   = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        pc_valid = 1'b1;
        // Priority: redirect > halt > stall > advance.
        if (redirect_valid) begin
          mux_sel = MUX_SEL_JMP;
          flush   = 1'b1;
          pc_next = mux_value;
        end else if (halt) begin
          state_next = ST_HALT;
          count_en   = 1'b1;
        end else if (!stall) begin
          pc_next  = mux_value;
          count_en = 1'b1;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        if (redirect_valid) begin
          mux_sel = MUX_SEL_JMP;
          flush   = 1'b1;
          pc_next = mux_value;
        end
        // A simultaneous halt keeps us parked.
        if (resume && !halt) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_BOOT;
        pc_next    = RESET_PC;
      end
    endcase
  end

  pc_sequencer_sat_counter #(
    .W (CNT_W)
  ) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .count (fetch_count)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-width instance plus a 4-bit
// counter instance on the same stimulus so counter saturation is reachable.
module tb_pc_sequencer;

  localparam int ADDR_W = 11;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              stall, redirect_valid, halt, resume;
  logic [ADDR_W-1:0] redirect_target;

  logic [ADDR_W-1:0] mux_value, pc_plus1, pc;
  logic              mux_sel, pc_valid, flush, halted;
  logic [15:0]       fetch_count;

  logic [ADDR_W-1:0] mux_value_s, pc_plus1_s, pc_s;
  logic              mux_sel_s, pc_valid_s, flush_s, halted_s;
  logic [3:0]        fetch_count_s;

  // External 2:1 next-PC muxes
  assign mux_value   = mux_sel   ? redirect_target : pc_plus1;
  assign mux_value_s = mux_sel_s ? redirect_target : pc_plus1_s;

  pc_sequencer dut (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .halt (halt), .resume (resume), .mux_value (mux_value),
    .pc_plus1 (pc_plus1), .mux_sel (mux_sel), .pc (pc), .pc_valid (pc_valid),
    .flush (flush), .halted (halted), .fetch_count (fetch_count)
  );

  pc_sequencer #(.CNT_W (4)) dut_s (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .halt (halt), .resume (resume), .mux_value (mux_value_s),
    .pc_plus1 (pc_plus1_s), .mux_sel (mux_sel_s), .pc (pc_s),
    .pc_valid (pc_valid_s), .flush (flush_s), .halted (halted_s),
    .fetch_count (fetch_count_s)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic rv, input logic [ADDR_W-1:0] tgt,
                       input logic h, input logic r);
    stall = s; redirect_valid = rv; redirect_target = tgt; halt = h; resume = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [ADDR_W-1:0] exp_pc[5];
  logic              exp_v[5];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #1;

    // reset state (BOOT)
    check("rst_pc", pc, 0);
    check("rst_valid", pc_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_flush", flush, 0);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_count", fetch_count, 0);

    // free run: pc 0,0,1,2,3 / valid 0,1,1,1,1
    exp_pc = '{11'd0, 11'd0, 11'd1, 11'd2, 11'd3};
    exp_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("run_pc%0d", i), pc, exp_pc[i]);
      check($sformatf("run_valid%0d", i), pc_valid, exp_v[i]);
      if (i < 4) tick();
    end
    check("run_count", fetch_count, 3);

    // redirect to 2047, then wrap to 0
    drive(0, 1, 11'd2047, 0, 0);
    check("r2047_mux_sel", mux_sel, 1);
    check("r2047_flush", flush, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("top_pc", pc, 2047);
    check("top_plus1", pc_plus1, 0);
    check("top_flush", flush, 0);
    check("top_count", fetch_count, 3);
    tick();
    check("wrap_pc", pc, 0);
    check("wrap_plus1", pc_plus1, 1);
    check("wrap_flush", flush, 0);
    check("wrap_mux_sel", mux_sel, 0);
    check("wrap_count", fetch_count, 4);

    // stall 3 cycles at pc 10
    drive(0, 1, 11'd10, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      check($sformatf("stall_pc%0d", i), pc, 10);
      check($sformatf("stall_mux%0d", i), mux_sel, 0);
      check($sformatf("stall_cnt%0d", i), fetch_count, 4);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    check("unstall_pc", pc, 10);
    tick();
    check("adv_pc", pc, 11);
    check("adv_count", fetch_count, 5);

    // stall + redirect same cycle at pc 20
    drive(0, 1, 11'd20, 0, 0);
    tick();
    drive(1, 1, 11'd300, 0, 0);
    check("sr_pc", pc, 20);
    check("sr_mux_sel", mux_sel, 1);
    check("sr_flush", flush, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("sr_target", pc, 300);
    check("sr_count", fetch_count, 5);

    // halt at pc 40
    drive(0, 1, 11'd40, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    check("h_pc", pc, 40);
    check("h_halted_pre", halted, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("h_halted", halted, 1);
    check("h_valid", pc_valid, 0);
    check("h_pc_hold", pc, 40);
    check("h_count", fetch_count, 6);
    tick();
    check("h_pc_hold2", pc, 40);
    drive(0, 1, 11'd100, 0, 0);
    check("h_redir_flush", flush, 1);
    check("h_redir_mux", mux_sel, 1);
    tick();
    drive(0, 0, 0, 1, 1);
    check("h_redir_pc", pc, 100);
    check("h_redir_halted", halted, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    check("h_both_halted", halted, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    check("res_halted", halted, 0);
    check("res_valid", pc_valid, 1);
    check("res_pc", pc, 100);
    tick();
    check("res_pc2", pc, 101);
    check("res_count", fetch_count, 7);

    // reset while halted
    drive(0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    check("rh_halted", halted, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rh_pc", pc, 0);
    check("rh_halted0", halted, 0);
    check("rh_valid", pc_valid, 0);
    check("rh_count", fetch_count, 0);

    // reset during a redirect
    tick();
    drive(0, 1, 11'd500, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    check("rr_pc", pc, 0);
    check("rr_valid", pc_valid, 0);
    check("rr_count", fetch_count, 0);

    // saturation on the 4-bit counter
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) check("sat_pre", fetch_count_s, 13);
      if (k == 16) check("sat_hit", fetch_count_s, 15);
    end
    check("sat_hold", fetch_count_s, 15);
    check("sat_big", fetch_count, 19);
    check("sat_pc", pc, 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
